// File: rtl/cnt_pkg.sv
// Shared definitions for the counter-sharing arbiter: FSM state encoding and default sizes.
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;

endpackage

// File: rtl/cnt_core.sv
// Clock-enabled, synchronously cleared W-bit up-counter that wraps to 0 on its terminal count.
module cnt_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         R,
  input  logic         ce,
  input  logic [W-1:0] len_q,
  output logic [W-1:0] Q,
  output logic         tc
);

  logic [W-1:0] q_q;

  // Terminal is the last tick of the interval; the counter returns to 0 on it.
  assign tc = ce & (q_q == len_q);
  assign Q  = q_q;

  always_ff @(posedge clk) begin
    if (R) begin
      q_q <= '0;
    end else if (tc) begin
      q_q <= '0;
    end else if (ce) begin
      q_q <= q_q + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_share_arb.sv
// Round-robin arbiter sharing one cnt_core among N_REQ requesters.
// Optional abort path (requester withdraws mid-grant) enabled by defining CNT_SHARE_ABORT_EN.
module cnt_share_arb
  import cnt_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic               clk,
  input  logic               R,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] len,
  input  logic               ce,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [W-1:0]       Q,
`ifdef CNT_SHARE_ABORT_EN
  output logic               abort,
`endif
  output state_t             dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: a requester holds req high until it sees its one-cycle done
  // (or abort); req is only looked at in IDLE unless the abort path is built.
  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [W-1:0]       len_q, len_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic               abort_hit;
  logic               cnt_clr;
  logic               cnt_ce;
  logic               tc;
  logic [IW-1:0]      ptr_after_win;

  // First requester found scanning upward from p, wrapping at N_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    p);
    logic [IW-1:0] sel;
    logic          found;
    int            j;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(p) + k) % N_REQ;
      if (!found && r[j]) begin
        sel   = IW'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign ptr_after_win = IW'((int'(win_q) + 1) % N_REQ);

`ifdef CNT_SHARE_ABORT_EN
  logic abort_q, abort_d;
  assign abort_hit = ((state_q == GRANT) || (state_q == COUNT)) && !req[win_q];
  assign abort     = abort_q;
`else
  assign abort_hit = 1'b0;
`endif

  // The counter only runs in COUNT; everywhere else it is held at 0.
  assign cnt_clr = R | (state_q != COUNT) | abort_hit;
  assign cnt_ce  = ce & (state_q == COUNT);

  cnt_core #(.W(W)) u_cnt (
    .clk   (clk),
    .R     (cnt_clr),
    .ce    (cnt_ce),
    .len_q (len_q),
    .Q     (Q),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    len_d   = len_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
`ifdef CNT_SHARE_ABORT_EN
    abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = rr_pick(req, ptr_q);
          gnt_d   = N_REQ'(1) << win_d;
          busy_d  = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        len_d   = len[int'(win_q)*W +: W];
        state_d = COUNT;
      end
      COUNT: begin
        if (tc) begin
          done_d  = gnt_q;
          ptr_d   = ptr_after_win;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      gnt_d   = '0;
      done_d  = '0;
      busy_d  = 1'b0;
      ptr_d   = ptr_after_win;
      state_d = IDLE;
`ifdef CNT_SHARE_ABORT_EN
      abort_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef CNT_SHARE_ABORT_EN
  always_ff @(posedge clk) begin
    if (R) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cnt_share_arb.sv
// Self-checking bench for cnt_share_arb: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_cnt_share_arb;
  import cnt_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  logic             clk;
  logic             R;
  logic [N-1:0]     req;
  logic [N*W-1:0]   len;
  logic             ce;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic             busy;
  logic [W-1:0]     Q;
  state_t           dbg_state;
`ifdef CNT_SHARE_ABORT_EN
  logic             abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model: grant phase, owner, remaining ticks of the interval
  int           m_ph;
  int           m_ptr;
  int           m_win;
  int           m_lat;
  int           m_left;
  logic [N-1:0] m_done;
  logic         m_abort;
  logic [7:0]   exp_q[$];
  logic [N-1:0] glog[$];
  logic [N-1:0] gnt_prev;

  cnt_share_arb #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .R         (R),
    .req       (req),
    .len       (len),
    .ce        (ce),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .Q         (Q),
`ifdef CNT_SHARE_ABORT_EN
    .abort     (abort),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int first_req_from(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // advance the model by one clock using the inputs present at the edge
  task automatic model_edge();
    int old_ph;
    old_ph  = m_ph;
    m_done  = '0;
    m_abort = 1'b0;
    if (R) begin
      m_ph = 0; m_ptr = 0; m_win = 0; m_lat = 0; m_left = 0;
      exp_q.delete();
      return;
    end
    if (old_ph == 0) begin
      if (req != '0) begin
        m_win = first_req_from(m_ptr, req);
        m_ph  = 1;
        exp_q.push_back(8'(m_win));
      end
    end else if (old_ph == 1) begin
      m_lat  = int'(len[m_win*W +: W]);
      m_left = m_lat + 1;
      m_ph   = 2;
    end else if (old_ph == 2) begin
      if (ce) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_ph   = 3;
          m_done = N'(1) << m_win;
          m_ptr  = (m_win + 1) % N;
        end
      end
    end else begin
      m_ph = 0;
    end
`ifdef CNT_SHARE_ABORT_EN
    if ((old_ph == 1 || old_ph == 2) && !req[m_win]) begin
      m_ph    = 0;
      m_done  = '0;
      m_abort = 1'b1;
      m_ptr   = (m_win + 1) % N;
      void'(exp_q.pop_back());
    end
`endif
  endtask

  function automatic logic [N-1:0] m_gnt();
    return (m_ph != 0) ? (N'(1) << m_win) : '0;
  endfunction

  function automatic logic [W-1:0] m_q();
    return (m_ph == 2) ? W'(m_lat + 1 - m_left) : '0;
  endfunction

  // driver: one clock, then compare all outputs with the model
  task automatic step();
    logic [7:0] front;
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt", gnt, m_gnt());
    chk("done", done, m_done);
    chk("busy", busy, m_ph != 0);
    chk("Q", Q, m_q());
    chk("state", dbg_state, m_ph);
    chk("gnt_onehot0", $onehot0(gnt), 1);
`ifdef CNT_SHARE_ABORT_EN
    chk("abort", abort, m_abort);
`endif
    if (done != '0) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", done, 0);
      end else begin
        front = exp_q.pop_front();
        chk("done_index", done, N'(1) << front);
      end
    end
    if (gnt != '0 && gnt_prev == '0) glog.push_back(gnt);
    gnt_prev = gnt;
  endtask

  task automatic do_reset(input int cycles);
    R = 1'b1;
    repeat (cycles) step();
    R = 1'b0;
  endtask

  task automatic set_len(input int idx, input int v);
    len[idx*W +: W] = W'(v);
  endtask

  // step until DUT done is seen; count cycles, timeout counts as a failure
  task automatic run_until_done(input string tag, input int bound, output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (done != '0) break;
      if (n >= bound) begin
        chk({tag, "_timeout"}, 1, 0);
        break;
      end
    end
  endtask

  initial begin
    int n, ticks, qmax;
    logic [N-1:0] exp_order[5];
    R = 1'b0; req = '0; len = '0; ce = 1'b0;
    m_ph = 0; m_ptr = 0; m_win = 0; m_lat = 0; m_left = 0;
    m_done = '0; m_abort = 1'b0; gnt_prev = '0;

    do_reset(2);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_Q", Q, 0);

    // single request, len 3, ce always on
    req = 4'b0001; set_len(0, 3); ce = 1'b1;
    n = 0;
    while (1) begin
      step();
      n++;
      if (n == 1) chk("t1_gnt", gnt, 4'b0001);
      if (n >= 2 && n <= 5) chk("t1_Q", Q, n - 2);
      if (done != '0 || n >= 20) break;
    end
    chk("t1_latency", n, 6);
    chk("t1_done", done, 4'b0001);
    req = '0;
    step();
    chk("t1_busy_fall", busy, 0);
    step();

    // all four requesting, len 1: strict round-robin order
    do_reset(1);
    glog.delete();
    req = 4'b1111; len = {4{4'd1}}; ce = 1'b1;
    n = 0;
    while (glog.size() < 5 && n < 60) begin
      step();
      n++;
    end
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("rr_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", glog[i], exp_order[i]);
    run_until_done("rr_tail", 20, n);
    req = '0;
    step();
    step();

    // ce toggling, len 2: three ticks after COUNT entry
    req = 4'b0010; set_len(1, 2); ce = 1'b0;
    step();
    step();
    chk("ce_in_count", dbg_state, COUNT);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      ce = (i % 2 == 0);
      step();
      if (ce) ticks++;
      if (done != '0) break;
    end
    chk("ce_ticks", ticks, 3);
    req = '0; ce = 1'b1;
    step();
    step();

    // full range, len 15
    req = 4'b0100; set_len(2, 15); ce = 1'b1;
    step();
    step();
    ticks = 0; qmax = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      ticks++;
      if (int'(Q) > qmax) qmax = int'(Q);
      if (done != '0) break;
    end
    chk("full_ticks", ticks, 16);
    chk("full_qmax", qmax, 15);
    chk("full_Q_wrap", Q, 0);
    req = '0;
    step();
    step();

    // reset mid-interval: ptr returns to 0
    req = 4'b0010; set_len(1, 0);
    run_until_done("pre_rst", 20, n);
    req = '0;
    step();
    step();
    req = 4'b1000; set_len(3, 5);
    for (int i = 0; i < 20 && Q != 2; i++) step();
    chk("rst_mid_Q", Q, 2);
    R = 1'b1; req = 4'b0110;
    step();
    chk("rst_mid_gnt", gnt, 0);
    chk("rst_mid_Q0", Q, 0);
    chk("rst_mid_done", done, 0);
    R = 1'b0; set_len(1, 1); set_len(2, 1);
    step();
    chk("rst_prio_gnt", gnt, 4'b0010);
    run_until_done("rst_g1", 20, n);
    req = 4'b0100;
    step();
    step();
    chk("rst_req2_gnt", gnt, 4'b0100);
    run_until_done("rst_g2", 20, n);
    req = '0;
    step();
    step();

`ifdef CNT_SHARE_ABORT_EN
    // drop the winner's request mid-count; the pending requester follows
    do_reset(1);
    req = 4'b0110; len = {4{4'd5}}; ce = 1'b1;
    step();
    step();
    step();
    chk("ab_gnt_before", gnt, 4'b0010);
    req = 4'b0100;
    step();
    chk("ab_pulse", abort, 1);
    chk("ab_gnt", gnt, 0);
    chk("ab_done", done, 0);
    chk("ab_Q", Q, 0);
    step();
    chk("ab_next_gnt", gnt, 4'b0100);
    chk("ab_pulse_once", abort, 0);
    run_until_done("ab_tail", 20, n);
    req = '0;
    step();
    step();
`endif

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      R  = ($urandom_range(0, 399) == 0);
      ce = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        set_len(i, $urandom_range(0, 7));
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      step();
      for (int i = 0; i < N; i++) begin
        if (m_done[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
